// File: rtl/lsu_pkg.sv
// Shared types and constants for the RV32I load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: FSM state enum and the RV32I funct3 width encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_e;

    // Access width encodings; store funct3 uses the same low three values.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/load_store_unit_if.sv
// Execute-side request/response and data-memory bus of the load/store unit.
// Latency: n/a (wires only).
// Backpressure: lsu_valid is held by the source until lsu_ready is seen at a posedge.
// Ports: lsu_* = execute handshake and payload, mem_* = single-port data memory.
//        slave modport is the unit itself; master modport is the surrounding pipeline/memory.
interface load_store_unit_if #(
    parameter int DataWidth = 32,
    parameter int Address   = 8
);
    logic                 lsu_valid;
    logic                 lsu_ready;
    logic                 lsu_is_store;
    logic [2:0]           lsu_funct3;
    logic [31:0]          lsu_addr;
    logic [DataWidth-1:0] lsu_wdata;
    logic                 lsu_done;
    logic [DataWidth-1:0] lsu_rdata;
    logic                 lsu_err;

    logic                 mem_request;
    logic                 mem_we_re;
    logic [3:0]           mem_mask;
    logic [Address-1:0]   mem_address;
    logic [DataWidth-1:0] mem_wdata;
    logic [DataWidth-1:0] mem_rdata;

    modport slave (
        input  lsu_valid, lsu_is_store, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata,
        output lsu_ready, lsu_done, lsu_rdata, lsu_err,
               mem_request, mem_we_re, mem_mask, mem_address, mem_wdata
    );

    modport master (
        output lsu_valid, lsu_is_store, lsu_funct3, lsu_addr, lsu_wdata, mem_rdata,
        input  lsu_ready, lsu_done, lsu_rdata, lsu_err,
               mem_request, mem_we_re, mem_mask, mem_address, mem_wdata
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a memory word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
// Ports: mem_rdata = raw word, funct3 = load type, offset = byte offset in word,
//        data = extended 32-bit load result.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (offset)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
    end

    // Halfwords are only ever aligned here, so offset[1] alone picks the half.
    assign half_sel = offset[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        data = mem_rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'd0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'd0, half_sel};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: byte address -> word address + lane mask, store replication, load extension.
// Latency: store done 2 cycles after accept, load 3, error 1; memory read is registered one cycle.
// Backpressure: lsu_ready is high only in IDLE, so one transaction is in flight at a time.
// Ports: clk/rst (sync active-high), bus = load_store_unit_if slave modport (lsu_* and mem_*).
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int Address   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    load_store_unit_if.slave     bus
);

    lsu_state_e           state_q;
    lsu_state_e           state_d;

    logic                 is_store_q;
    logic [2:0]           funct3_q;
    logic [1:0]           off_q;
    logic [Address-1:0]   waddr_q;
    logic [DataWidth-1:0] wdata_q;
    logic [3:0]           mask_q;
    logic                 err_q;
    logic [DataWidth-1:0] rdata_q;

    logic                 accept;
    logic                 req_err;
    logic [3:0]           req_mask;
    logic [DataWidth-1:0] req_wdata;
    logic [DataWidth-1:0] load_val;

    // Address bits above the memory depth are dropped on purpose (wrap-around).
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.lsu_addr[31:Address+2];

    assign accept = (state_q == IDLE) && bus.lsu_valid;

    // Misalignment and illegal funct3 detection on the incoming request.
    always_comb begin
        req_err = 1'b0;
        if (bus.lsu_is_store) begin
            case (bus.lsu_funct3)
                F3_B:    req_err = 1'b0;
                F3_H:    req_err = bus.lsu_addr[0];
                F3_W:    req_err = |bus.lsu_addr[1:0];
                default: req_err = 1'b1;
            endcase
        end else begin
            case (bus.lsu_funct3)
                F3_B, F3_BU: req_err = 1'b0;
                F3_H, F3_HU: req_err = bus.lsu_addr[0];
                F3_W:        req_err = |bus.lsu_addr[1:0];
                default:     req_err = 1'b1;
            endcase
        end
    end

    // Lane mask and replicated write data; loads always read the full word.
    always_comb begin
        req_mask  = 4'b1111;
        req_wdata = bus.lsu_wdata;
        if (bus.lsu_is_store) begin
            case (bus.lsu_funct3)
                F3_B: begin
                    req_mask  = 4'b0001 << bus.lsu_addr[1:0];
                    req_wdata = {4{bus.lsu_wdata[7:0]}};
                end
                F3_H: begin
                    req_mask  = bus.lsu_addr[1] ? 4'b1100 : 4'b0011;
                    req_wdata = {2{bus.lsu_wdata[15:0]}};
                end
                default: begin
                    req_mask  = 4'b1111;
                    req_wdata = bus.lsu_wdata;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? DONE : REQ;
            REQ:     state_d = is_store_q ? DONE : WAIT;
            WAIT:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // Capture registers; cleared by reset so the memory bus returns to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            off_q      <= 2'd0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            mask_q     <= 4'd0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            if (accept) begin
                is_store_q <= bus.lsu_is_store;
                funct3_q   <= bus.lsu_funct3;
                off_q      <= bus.lsu_addr[1:0];
                waddr_q    <= bus.lsu_addr[Address+1:2];
                wdata_q    <= req_wdata;
                mask_q     <= req_mask;
                err_q      <= req_err;
            end
            // Memory data is valid during WAIT; latch the extended value at its end.
            if (state_q == WAIT) begin
                rdata_q <= load_val;
            end
        end
    end

    load_align u_load_align (
        .mem_rdata (bus.mem_rdata),
        .funct3    (funct3_q),
        .offset    (off_q),
        .data      (load_val)
    );

    assign bus.lsu_ready   = (state_q == IDLE);
    assign bus.lsu_done    = (state_q == DONE);
    assign bus.lsu_err     = (state_q == DONE) && err_q;
    assign bus.lsu_rdata   = rdata_q;
    assign bus.mem_request = (state_q == REQ);
    assign bus.mem_we_re   = (state_q == REQ) && is_store_q;
    assign bus.mem_mask    = (state_q == REQ) ? mask_q : 4'd0;
    assign bus.mem_address = waddr_q;
    assign bus.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a registered-read memory model.
// Latency: checks exact cycle positions of request, done and ready.
// Backpressure: holds lsu_valid across a busy unit to confirm acceptance timing.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;
    int   req_cnt = 0;

    logic [31:0] mem [256];

    load_store_unit_if #(.DataWidth(32), .Address(8)) ifc ();

    load_store_unit #(.DataWidth(32), .Address(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    always #5 clk = ~clk;

    // Data memory: byte-masked writes, read data registered one cycle later.
    always @(posedge clk) begin
        if (ifc.mem_request) begin
            req_cnt = req_cnt + 1;
            if (ifc.mem_we_re) begin
                for (int b = 0; b < 4; b++)
                    if (ifc.mem_mask[b]) mem[ifc.mem_address][8*b +: 8] <= ifc.mem_wdata[8*b +: 8];
            end else begin
                ifc.mem_rdata <= mem[ifc.mem_address];
            end
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request at a negedge, returns at the negedge of T+1 with valid dropped
    // and the payload scrambled to show later input changes are ignored.
    task automatic issue(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clk);
        check_vec({tag, " ready_before"}, 32'(ifc.lsu_ready), 32'd1);
        ifc.lsu_valid    = 1'b1;
        ifc.lsu_is_store = st;
        ifc.lsu_funct3   = f3;
        ifc.lsu_addr     = addr;
        ifc.lsu_wdata    = wdata;
        @(posedge clk);
        @(negedge clk);
        ifc.lsu_valid    = 1'b0;
        ifc.lsu_is_store = ~st;
        ifc.lsu_addr     = 32'hFFFF_FFFF;
        ifc.lsu_wdata    = 32'h0BAD_F00D;
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [7:0] e_addr,
                            input logic [3:0] e_mask, input logic [31:0] e_wdata);
        issue(tag, 1'b1, f3, addr, wdata);
        check_vec({tag, " req"},   32'(ifc.mem_request), 32'd1);
        check_vec({tag, " we"},    32'(ifc.mem_we_re),   32'd1);
        check_vec({tag, " addr"},  32'(ifc.mem_address), 32'(e_addr));
        check_vec({tag, " mask"},  32'(ifc.mem_mask),    32'(e_mask));
        check_vec({tag, " wdata"}, ifc.mem_wdata,        e_wdata);
        check_vec({tag, " busy1"}, 32'(ifc.lsu_ready),   32'd0);
        @(negedge clk);
        check_vec({tag, " done"},  32'(ifc.lsu_done),    32'd1);
        check_vec({tag, " err"},   32'(ifc.lsu_err),     32'd0);
        check_vec({tag, " req2"},  32'(ifc.mem_request), 32'd0);
        check_vec({tag, " mask2"}, 32'(ifc.mem_mask),    32'd0);
        @(negedge clk);
        check_vec({tag, " ready"}, 32'(ifc.lsu_ready),   32'd1);
        check_vec({tag, " done3"}, 32'(ifc.lsu_done),    32'd0);
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [7:0] e_addr, input logic [31:0] e_rdata);
        issue(tag, 1'b0, f3, addr, 32'h0);
        check_vec({tag, " req"},   32'(ifc.mem_request), 32'd1);
        check_vec({tag, " we"},    32'(ifc.mem_we_re),   32'd0);
        check_vec({tag, " mask"},  32'(ifc.mem_mask),    32'hF);
        check_vec({tag, " addr"},  32'(ifc.mem_address), 32'(e_addr));
        @(negedge clk);
        check_vec({tag, " done2"}, 32'(ifc.lsu_done),    32'd0);
        check_vec({tag, " busy2"}, 32'(ifc.lsu_ready),   32'd0);
        check_vec({tag, " req2"},  32'(ifc.mem_request), 32'd0);
        @(negedge clk);
        check_vec({tag, " done"},  32'(ifc.lsu_done),    32'd1);
        check_vec({tag, " err"},   32'(ifc.lsu_err),     32'd0);
        check_vec({tag, " rdata"}, ifc.lsu_rdata,        e_rdata);
        @(negedge clk);
        check_vec({tag, " ready"}, 32'(ifc.lsu_ready),   32'd1);
        check_vec({tag, " hold"},  ifc.lsu_rdata,        e_rdata);
    endtask

    task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] e_rdata);
        int c0;
        c0 = req_cnt;
        issue(tag, st, f3, addr, 32'h1111_2222);
        check_vec({tag, " done"},  32'(ifc.lsu_done),    32'd1);
        check_vec({tag, " err"},   32'(ifc.lsu_err),     32'd1);
        check_vec({tag, " req"},   32'(ifc.mem_request), 32'd0);
        check_vec({tag, " rdata"}, ifc.lsu_rdata,        e_rdata);
        @(negedge clk);
        check_vec({tag, " ready"}, 32'(ifc.lsu_ready),   32'd1);
        check_vec({tag, " done2"}, 32'(ifc.lsu_done),    32'd0);
        check_vec({tag, " err2"},  32'(ifc.lsu_err),     32'd0);
        check_vec({tag, " nreq"},  32'(req_cnt - c0),    32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_vec({tag, " ready"}, 32'(ifc.lsu_ready),   32'd1);
        check_vec({tag, " done"},  32'(ifc.lsu_done),    32'd0);
        check_vec({tag, " err"},   32'(ifc.lsu_err),     32'd0);
        check_vec({tag, " rdata"}, ifc.lsu_rdata,        32'd0);
        check_vec({tag, " req"},   32'(ifc.mem_request), 32'd0);
        check_vec({tag, " we"},    32'(ifc.mem_we_re),   32'd0);
        check_vec({tag, " mask"},  32'(ifc.mem_mask),    32'd0);
        check_vec({tag, " addr"},  32'(ifc.mem_address), 32'd0);
        check_vec({tag, " wdata"}, ifc.mem_wdata,        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.lsu_valid    = 1'b0;
        ifc.lsu_is_store = 1'b0;
        ifc.lsu_funct3   = 3'd0;
        ifc.lsu_addr     = 32'd0;
        ifc.lsu_wdata    = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst0");

        // Stores and lane placement into word 0x04.
        do_store("sw",  F3_W, 32'h0000_0010, 32'hDEAD_BEEF, 8'h04, 4'b1111, 32'hDEAD_BEEF);
        do_store("sb",  F3_B, 32'h0000_0013, 32'h0000_00A5, 8'h04, 4'b1000, 32'hA5A5_A5A5);
        do_store("sh",  F3_H, 32'h0000_0012, 32'h0000_1234, 8'h04, 4'b1100, 32'h1234_1234);
        do_load ("lw_merge", F3_W, 32'h0000_0010, 8'h04, 32'h1234_BEEF);
        do_store("sb0", F3_B, 32'h0000_0010, 32'h0000_0077, 8'h04, 4'b0001, 32'h7777_7777);
        do_store("sh0", F3_H, 32'h0000_0010, 32'h0000_5A5A, 8'h04, 4'b0011, 32'h5A5A_5A5A);
        do_store("sw2", F3_W, 32'h0000_0010, 32'h80FF_7F01, 8'h04, 4'b1111, 32'h80FF_7F01);

        // Load extraction from 0x80FF7F01.
        do_load("lb1",  F3_B,  32'h0000_0011, 8'h04, 32'h0000_007F);
        do_load("lb3",  F3_B,  32'h0000_0013, 8'h04, 32'hFFFF_FF80);
        do_load("lbu3", F3_BU, 32'h0000_0013, 8'h04, 32'h0000_0080);
        do_load("lh2",  F3_H,  32'h0000_0012, 8'h04, 32'hFFFF_80FF);
        do_load("lhu2", F3_HU, 32'h0000_0012, 8'h04, 32'h0000_80FF);
        do_load("lhu0", F3_HU, 32'h0000_0010, 8'h04, 32'h0000_7F01);
        do_load("lw",   F3_W,  32'h0000_0010, 8'h04, 32'h80FF_7F01);

        // Errors leave rdata at the last load result.
        do_err("lw_mis",  1'b0, F3_W,   32'h0000_0011, 32'h80FF_7F01);
        do_err("sh_mis",  1'b1, F3_H,   32'h0000_0001, 32'h80FF_7F01);
        do_err("ld_f3_3", 1'b0, 3'b011, 32'h0000_0010, 32'h80FF_7F01);
        do_err("st_f3_4", 1'b1, 3'b100, 32'h0000_0010, 32'h80FF_7F01);

        // Back-to-back: load held valid while the store is in flight; 0x420 wraps to word 0x08.
        @(negedge clk);
        ifc.lsu_valid    = 1'b1;
        ifc.lsu_is_store = 1'b1;
        ifc.lsu_funct3   = F3_W;
        ifc.lsu_addr     = 32'h0000_0020;
        ifc.lsu_wdata    = 32'h55AA_55AA;
        @(posedge clk);
        @(negedge clk);
        ifc.lsu_is_store = 1'b0;
        ifc.lsu_addr     = 32'h0000_0420;
        ifc.lsu_wdata    = 32'h0;
        check_vec("b2b st_busy1", 32'(ifc.lsu_ready),   32'd0);
        check_vec("b2b st_we",    32'(ifc.mem_we_re),   32'd1);
        check_vec("b2b st_addr",  32'(ifc.mem_address), 32'h08);
        @(negedge clk);
        check_vec("b2b st_busy2", 32'(ifc.lsu_ready),   32'd0);
        check_vec("b2b st_done",  32'(ifc.lsu_done),    32'd1);
        check_vec("b2b no_req2",  32'(ifc.mem_request), 32'd0);
        @(negedge clk);
        check_vec("b2b ready3",   32'(ifc.lsu_ready),   32'd1);
        check_vec("b2b no_req3",  32'(ifc.mem_request), 32'd0);
        @(posedge clk);
        @(negedge clk);
        ifc.lsu_valid = 1'b0;
        check_vec("b2b ld_req",   32'(ifc.mem_request), 32'd1);
        check_vec("b2b ld_we",    32'(ifc.mem_we_re),   32'd0);
        check_vec("b2b ld_addr",  32'(ifc.mem_address), 32'h08);
        @(negedge clk);
        @(negedge clk);
        check_vec("b2b ld_done",  32'(ifc.lsu_done),    32'd1);
        check_vec("b2b ld_rdata", ifc.lsu_rdata,        32'h55AA_55AA);

        // Reset during WAIT aborts the load with no done pulse.
        issue("abort", 1'b0, F3_W, 32'h0000_0010, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
        @(negedge clk);
        check_vec("rst_mid no_done", 32'(ifc.lsu_done), 32'd0);
        check_vec("rst_mid rdata2",  ifc.lsu_rdata,     32'd0);
        do_load("lw_after", F3_W, 32'h0000_0420, 8'h08, 32'h55AA_55AA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
